// File: rtl/port_rd_frontend.sv
`default_nettype none
// +------------------------------------------------------------------+
// | port_rd_frontend: egress FIFO replaying backend half-words as     |
// | sop/vld/eop framed packets, cut-through.  Rev 1.0                 |
// +------------------------------------------------------------------+
module port_rd_frontend #(
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned PAUSE_MARGIN = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        xfer_data_vld_i,
  input  logic [15:0] xfer_data_i,
  input  logic        end_of_packet_i,
  output logic        xfer_pause_o,
  input  logic        ready_i,
  output logic        rd_sop_o,
  output logic        rd_vld_o,
  output logic [15:0] rd_data_o,
  output logic        rd_eop_o,
  output logic        overflow_o
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] c_DEPTH  = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_MARGIN = (AW+1)'(PAUSE_MARGIN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SOP  = 2'd1,
    S_DATA = 2'd2,
    S_EOP  = 2'd3
  } state_e;

  logic [16:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          pause_q;
  logic          overflow_q;

  state_e        state_q;
  logic          sop_q;
  logic          vld_q;
  logic          eop_q;
  logic          last_q;
  logic [15:0]   data_q;

  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic [16:0]   w_rd_word;

  assign w_push    = xfer_data_vld_i && (count_q < c_DEPTH);
  assign w_drop    = xfer_data_vld_i && (count_q == c_DEPTH);
  // Pops happen on the edge that opens a DATA cycle, so rd_vld is registered.
  assign w_pop     = ((state_q == S_SOP) || ((state_q == S_DATA) && !last_q))
                     && (count_q != '0);
  assign w_rd_word = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(w_push);
    rd_ptr_d = rd_ptr_q + AW'(w_pop);
    count_d  = count_q + (AW+1)'(w_push) - (AW+1)'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= {end_of_packet_i, xfer_data_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pause_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pause_q    <= (c_DEPTH - count_q) <= c_MARGIN;
      overflow_q <= overflow_q | w_drop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sop_q   <= 1'b0;
      vld_q   <= 1'b0;
      eop_q   <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= 16'h0000;
    end else begin
      sop_q <= 1'b0;
      vld_q <= 1'b0;
      eop_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ready_i && (count_q != '0)) begin
            state_q <= S_SOP;
            sop_q   <= 1'b1;
          end
        end
        S_SOP, S_DATA: begin
          // last_q marks that the half-word on the output carried the flag bit
          if ((state_q == S_DATA) && last_q) begin
            state_q <= S_EOP;
            eop_q   <= 1'b1;
            last_q  <= 1'b0;
          end else begin
            state_q <= S_DATA;
            if (w_pop) begin
              vld_q  <= 1'b1;
              data_q <= w_rd_word[15:0];
              last_q <= w_rd_word[16];
            end
          end
        end
        S_EOP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign xfer_pause_o = pause_q;
  assign overflow_o   = overflow_q;
  assign rd_sop_o     = sop_q;
  assign rd_vld_o     = vld_q;
  assign rd_eop_o     = eop_q;
  assign rd_data_o    = data_q;

endmodule
`default_nettype wire

// File: tb/tb_port_rd_frontend.sv
`default_nettype none
// Testbench for port_rd_frontend: cycle vector table plus directed
// fill/backpressure, wrap/back-to-back and reset-mid-packet sequences.
module tb_port_rd_frontend;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        xv  = 1'b0;
  logic [15:0] xd  = 16'h0000;
  logic        xe  = 1'b0;
  logic        ready = 1'b0;
  logic        pause;
  logic        rd_sop;
  logic        rd_vld;
  logic [15:0] rd_data;
  logic        rd_eop;
  logic        ovf;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] exp_q [$];

  port_rd_frontend #(.DEPTH(64), .PAUSE_MARGIN(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .xfer_data_vld_i (xv),
    .xfer_data_i     (xd),
    .end_of_packet_i (xe),
    .xfer_pause_o    (pause),
    .ready_i         (ready),
    .rd_sop_o        (rd_sop),
    .rd_vld_o        (rd_vld),
    .rd_data_o       (rd_data),
    .rd_eop_o        (rd_eop),
    .overflow_o      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        vld;
    logic [15:0] data;
    logic        eop;
    logic        rdy;
    logic [20:0] exp;  // {sop, vld, eop, pause, overflow, data}
  } vec_t;

  vec_t vecs [$];

  function automatic void add(input logic r, input logic v, input logic [15:0] d,
                              input logic e, input logic rdy, input logic xs,
                              input logic xvl, input logic xeo, input logic [15:0] xdat);
    vec_t t;
    t.rst  = r;
    t.vld  = v;
    t.data = d;
    t.eop  = e;
    t.rdy  = rdy;
    t.exp  = {xs, xvl, xeo, 1'b0, 1'b0, xdat};
    vecs.push_back(t);
  endfunction

  function automatic logic [20:0] outs();
    return {rd_sop, rd_vld, rd_eop, pause, ovf, rd_data};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; xv = 1'b0; xe = 1'b0; xd = 16'h0000; ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset outputs", 32'(outs()), 32'd0);
    rst = 1'b0;
  endtask

  task automatic drain_check(input string nm);
    logic got;
    ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #1;
      if (rd_sop) got = 1'b1;
    end
    chk({nm, " sop"}, 32'(got), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clk); #1;
      if (rd_vld) begin
        if (exp_q.size() == 0) chk({nm, " extra word"}, 32'(rd_data), 32'hFFFF_FFFF);
        else chk({nm, " data"}, 32'(rd_data), 32'(exp_q.pop_front()));
      end
      if (rd_eop) got = 1'b1;
    end
    chk({nm, " eop"}, 32'(got), 32'd1);
    chk({nm, " words left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int  nsop, neop, nwords, last_eop;
    logic wait_first, seen;

    // rst, vld, data, eop, rdy | sop, vld, eop, data
    add(1, 0, 16'h0000, 0, 0,  0, 0, 0, 16'h0000);
    add(1, 0, 16'h0000, 0, 0,  0, 0, 0, 16'h0000);
    // single 4-word packet
    add(0, 1, 16'h0011, 0, 1,  0, 0, 0, 16'h0000);
    add(0, 1, 16'h0012, 0, 1,  1, 0, 0, 16'h0000);
    add(0, 1, 16'h0013, 0, 1,  0, 1, 0, 16'h0011);
    add(0, 1, 16'h0014, 1, 1,  0, 1, 0, 16'h0012);
    add(0, 0, 16'h0000, 0, 1,  0, 1, 0, 16'h0013);
    add(0, 0, 16'h0000, 0, 1,  0, 1, 0, 16'h0014);
    add(0, 0, 16'h0000, 0, 1,  0, 0, 1, 16'h0014);
    add(0, 0, 16'h0000, 0, 1,  0, 0, 0, 16'h0014);
    add(0, 0, 16'h0000, 0, 1,  0, 0, 0, 16'h0014);
    // mid-packet gap: 2 words, 5 stalled cycles, 2 words
    add(0, 1, 16'h0021, 0, 1,  0, 0, 0, 16'h0014);
    add(0, 1, 16'h0022, 0, 1,  1, 0, 0, 16'h0014);
    add(0, 0, 16'h0000, 0, 1,  0, 1, 0, 16'h0021);
    add(0, 0, 16'h0000, 0, 1,  0, 1, 0, 16'h0022);
    add(0, 0, 16'h0000, 0, 1,  0, 0, 0, 16'h0022);
    add(0, 0, 16'h0000, 0, 1,  0, 0, 0, 16'h0022);
    add(0, 0, 16'h0000, 0, 1,  0, 0, 0, 16'h0022);
    add(0, 1, 16'h0023, 0, 1,  0, 0, 0, 16'h0022);
    add(0, 1, 16'h0024, 1, 1,  0, 1, 0, 16'h0023);
    add(0, 0, 16'h0000, 0, 1,  0, 1, 0, 16'h0024);
    add(0, 0, 16'h0000, 0, 1,  0, 0, 1, 16'h0024);
    add(0, 0, 16'h0000, 0, 1,  0, 0, 0, 16'h0024);
    // ready gating: buffered packet waits, ready dropped during DATA
    add(0, 1, 16'h0031, 0, 0,  0, 0, 0, 16'h0024);
    add(0, 1, 16'h0032, 1, 0,  0, 0, 0, 16'h0024);
    add(0, 0, 16'h0000, 0, 0,  0, 0, 0, 16'h0024);
    add(0, 0, 16'h0000, 0, 0,  0, 0, 0, 16'h0024);
    add(0, 0, 16'h0000, 0, 0,  0, 0, 0, 16'h0024);
    add(0, 0, 16'h0000, 0, 1,  1, 0, 0, 16'h0024);
    add(0, 0, 16'h0000, 0, 0,  0, 1, 0, 16'h0031);
    add(0, 0, 16'h0000, 0, 0,  0, 1, 0, 16'h0032);
    add(0, 0, 16'h0000, 0, 0,  0, 0, 1, 16'h0032);
    add(0, 0, 16'h0000, 0, 0,  0, 0, 0, 16'h0032);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; xv = vecs[i].vld; xd = vecs[i].data;
      xe = vecs[i].eop; ready = vecs[i].rdy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Fill with sink held off, then check pause threshold and overflow
    do_reset();
    exp_q.delete();
    for (int k = 0; k < 64; k++) begin
      xv = 1'b1; xd = 16'(32'h0100 + k); xe = (k == 63);
      exp_q.push_back(16'(32'h0100 + k));
      @(posedge clk); #1;
      chk($sformatf("pause after push %0d", k), 32'(pause), 32'(k >= 61));
      chk($sformatf("no ovf push %0d", k), 32'(ovf), 32'd0);
    end
    xv = 1'b1; xd = 16'hBEEF; xe = 1'b1;
    @(posedge clk); #1;
    xv = 1'b0; xe = 1'b0;
    chk("overflow on 65th push", 32'(ovf), 32'd1);
    chk("pause while full", 32'(pause), 32'd1);
    drain_check("fill drain");
    chk("overflow sticky", 32'(ovf), 32'd1);

    // Three 40-word packets streamed back-to-back; pointers wrap
    do_reset();
    exp_q.delete();
    for (int k = 0; k < 120; k++) exp_q.push_back(16'(32'h1000 + k));
    nsop = 0; neop = 0; nwords = 0; last_eop = 0; wait_first = 1'b0;
    ready = 1'b1;
    for (int c = 0; c < 220; c++) begin
      if (c < 120) begin
        xv = 1'b1; xd = 16'(32'h1000 + c); xe = ((c % 40) == 39);
      end else begin
        xv = 1'b0; xe = 1'b0;
      end
      @(posedge clk); #1;
      if (rd_sop) nsop++;
      if (rd_vld) begin
        if (wait_first) begin
          chk("idle cycles eop->vld", 32'(c - last_eop - 1), 32'd2);
          wait_first = 1'b0;
        end
        if (exp_q.size() == 0) chk("wrap extra word", 32'(rd_data), 32'hFFFF_FFFF);
        else chk("wrap data", 32'(rd_data), 32'(exp_q.pop_front()));
        nwords++;
      end
      if (rd_eop) begin
        neop++; last_eop = c; wait_first = 1'b1;
      end
    end
    chk("wrap sop count", 32'(nsop), 32'd3);
    chk("wrap eop count", 32'(neop), 32'd3);
    chk("wrap word count", 32'(nwords), 32'd120);

    // Reset asserted while the packet is in DATA
    do_reset();
    ready = 1'b1; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      xv = 1'b1; xd = 16'(32'h0041 + i); xe = (i == 9);
      @(posedge clk); #1;
      if (rd_vld && rd_data == 16'h0043) seen = 1'b1;
    end
    xv = 1'b0; xe = 1'b0;
    chk("mid-packet word seen", 32'(seen), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("outputs after mid rst", 32'(outs()), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("quiet after rst", 32'({rd_sop, rd_vld, rd_eop}), 32'd0);
    end
    ready = 1'b0;
    xv = 1'b1; xd = 16'h0051; xe = 1'b0;
    @(posedge clk); #1;
    xv = 1'b1; xd = 16'h0052; xe = 1'b1;
    @(posedge clk); #1;
    xv = 1'b0; xe = 1'b0;
    exp_q.delete();
    exp_q.push_back(16'h0051);
    exp_q.push_back(16'h0052);
    drain_check("post rst packet");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
